// File: rtl/mesi_pkg.sv
// rtl/mesi_pkg.sv - MESI state codes and line controller FSM encoding
package mesi_pkg;

  localparam logic [1:0] ST_M = 2'b00;
  localparam logic [1:0] ST_E = 2'b01;
  localparam logic [1:0] ST_S = 2'b11;
  localparam logic [1:0] ST_I = 2'b10;

  typedef enum logic {
    CTRL_IDLE       = 1'b0,
    CTRL_FLUSH_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/mesi_next_state.sv
// rtl/mesi_next_state.sv - per-line MESI next-state and bus request decode
// When flush_req is set, next_state is the state the line takes once the write-back is acknowledged.
module mesi_next_state
  import mesi_pkg::*;
(
  input  logic [1:0] cur_state,
  input  logic       pr,
  input  logic       pw,
  input  logic       br,
  input  logic       bw,
  input  logic       s,
  output logic [1:0] next_state,
  output logic       bus_rd,
  output logic       bus_rdx,
  output logic       flush_req
);

  always_comb begin
    next_state = cur_state;
    bus_rd     = 1'b0;
    bus_rdx    = 1'b0;
    flush_req  = 1'b0;
    if (bw) begin
      next_state = ST_I;
      flush_req  = (cur_state == ST_M);
    end else if (br) begin
      if (cur_state != ST_I) next_state = ST_S;
      flush_req = (cur_state == ST_M);
    end else if (pw) begin
      next_state = ST_M;
      bus_rdx    = (cur_state == ST_I) || (cur_state == ST_S);
    end else if (pr) begin
      if (cur_state == ST_I) begin
        bus_rd     = 1'b1;
        next_state = s ? ST_S : ST_E;
      end
    end
  end

endmodule

// File: rtl/mesi_line_ctrl.sv
// rtl/mesi_line_ctrl.sv - multi-line MESI controller with bus requests and dirty-line flush handshake
module mesi_line_ctrl
  import mesi_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pr,
  input  logic             pw,
  input  logic [IDX_W-1:0] p_idx,
  input  logic             br,
  input  logic             bw,
  input  logic [IDX_W-1:0] b_idx,
  input  logic             s,
  input  logic             flush_ack,
  input  logic [IDX_W-1:0] q_idx,
  output logic             p_ready,
  output logic             b_ready,
  output logic             bus_rd,
  output logic             bus_rdx,
  output logic [IDX_W-1:0] bus_idx,
  output logic             flush,
  output logic [IDX_W-1:0] flush_idx,
  output logic [1:0]       q_state
);

  logic [1:0]       line_q [NUM_LINES];
  logic [1:0]       line_d [NUM_LINES];
  ctrl_state_e      ctrl_q, ctrl_d;
  logic [1:0]       tgt_q, tgt_d;
  logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
  logic [IDX_W-1:0] bus_idx_q, bus_idx_d;
  logic             bus_rd_q, bus_rd_d;
  logic             bus_rdx_q, bus_rdx_d;

  logic       p_ok, b_ok, q_ok;
  logic [1:0] p_cur, b_cur;
  logic [1:0] p_next, b_next;
  logic       p_rd, p_rdx, p_flush_req;
  logic       b_rd, b_rdx, b_flush_req;
  logic       snoop_act, snoop_req, snoop_flush, proc_req;
  logic       unused_paths;

  assign p_ok = (int'(p_idx) < NUM_LINES);
  assign b_ok = (int'(b_idx) < NUM_LINES);
  assign q_ok = (int'(q_idx) < NUM_LINES);

  assign p_cur = p_ok ? line_q[p_idx] : ST_I;
  assign b_cur = b_ok ? line_q[b_idx] : ST_I;

  mesi_next_state u_proc_ns (
    .cur_state (p_cur),
    .pr        (pr),
    .pw        (pw),
    .br        (1'b0),
    .bw        (1'b0),
    .s         (s),
    .next_state(p_next),
    .bus_rd    (p_rd),
    .bus_rdx   (p_rdx),
    .flush_req (p_flush_req)
  );

  mesi_next_state u_snoop_ns (
    .cur_state (b_cur),
    .pr        (1'b0),
    .pw        (1'b0),
    .br        (br),
    .bw        (bw),
    .s         (1'b0),
    .next_state(b_next),
    .bus_rd    (b_rd),
    .bus_rdx   (b_rdx),
    .flush_req (b_flush_req)
  );

  assign unused_paths = ^{p_flush_req, b_rd, b_rdx};

  // A snoop on the same line, or one that starts a flush, stalls the processor for this cycle.
  assign b_ready     = rst & (ctrl_q == CTRL_IDLE);
  assign snoop_act   = br | bw;
  assign snoop_req   = b_ready & snoop_act & b_ok;
  assign snoop_flush = snoop_req & b_flush_req;
  assign p_ready     = b_ready & ~(snoop_act & (p_idx == b_idx)) & ~snoop_flush;
  assign proc_req    = p_ready & (pr | pw) & p_ok;

  always_comb begin
    line_d      = line_q;
    ctrl_d      = ctrl_q;
    tgt_d       = tgt_q;
    flush_idx_d = flush_idx_q;
    bus_idx_d   = bus_idx_q;
    bus_rd_d    = 1'b0;
    bus_rdx_d   = 1'b0;
    if (ctrl_q == CTRL_IDLE) begin
      if (snoop_flush) begin
        ctrl_d      = CTRL_FLUSH_WAIT;
        tgt_d       = b_next;
        flush_idx_d = b_idx;
      end else if (snoop_req) begin
        line_d[b_idx] = b_next;
      end
      if (proc_req) begin
        line_d[p_idx] = p_next;
        bus_rd_d      = p_rd;
        bus_rdx_d     = p_rdx;
        if (p_rd | p_rdx) bus_idx_d = p_idx;
      end
    end else if (flush_ack) begin
      line_d[flush_idx_q] = tgt_q;
      ctrl_d              = CTRL_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_LINES; i++) line_q[i] <= ST_I;
      ctrl_q      <= CTRL_IDLE;
      tgt_q       <= ST_I;
      flush_idx_q <= '0;
      bus_idx_q   <= '0;
      bus_rd_q    <= 1'b0;
      bus_rdx_q   <= 1'b0;
    end else begin
      line_q      <= line_d;
      ctrl_q      <= ctrl_d;
      tgt_q       <= tgt_d;
      flush_idx_q <= flush_idx_d;
      bus_idx_q   <= bus_idx_d;
      bus_rd_q    <= bus_rd_d;
      bus_rdx_q   <= bus_rdx_d;
    end
  end

  assign bus_rd    = bus_rd_q;
  assign bus_rdx   = bus_rdx_q;
  assign bus_idx   = bus_idx_q;
  assign flush     = (ctrl_q == CTRL_FLUSH_WAIT);
  assign flush_idx = flush_idx_q;
  assign q_state   = q_ok ? line_q[q_idx] : ST_I;

endmodule
